v60_alu_result_stage: RTL and testbench

- Pipeline stage directly downstream of the V60 ALU.
- Captures the ALU result and flags, narrows Z/S to the operand size, and commits the flags to the PSW condition-flag register under a per-flag write mask.
- Buffers results in a 2-entry skid FIFO toward register writeback.
- Evaluates the 16 branch condition codes against the committed flags.

---
 rtl/v60_alu_result_stage.sv | 166 ++++++++++++++++
 tb/tb_v60_alu_result_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/v60_alu_result_stage.sv
// V60 ALU result stage: size narrowing, masked PSW flag commit, skid FIFO to writeback, branch conditions.
// Optional V60_ALU_RESULT_FLAG_BYPASS_EN: conditions evaluate against next-state flags (no flag-to-branch bubble).
module v60_alu_result_stage #(
  parameter int DEPTH  = 2,
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_result,
  input  logic              in_c,
  input  logic              in_v,
  input  logic              in_z,
  input  logic              in_s,
  input  logic [1:0]        in_size,
  input  logic [3:0]        in_flag_we,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_wb_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [3:0]        out_byte_en,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_wb_en,
  input  logic              psw_we,
  input  logic [3:0]        psw_wdata,
  output logic [3:0]        psw_flags,
  input  logic [3:0]        cond_code,
  output logic              cond_true
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]       result;
    logic [3:0]        byte_en;
    logic [DEST_W-1:0] dest;
    logic              wb_en;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            hold;
  entry_t            head;
  entry_t            new_entry;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              accept;
  logic              drain;
  logic              nar_z;
  logic              nar_s;
  logic [3:0]        new_flags;
  logic [3:0]        psw_next;
  logic [3:0]        cond_flags;

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_comb begin
    new_entry       = '0;
    new_entry.dest  = in_dest;
    new_entry.wb_en = in_wb_en;
    nar_z           = in_z;
    nar_s           = in_s;
    case (in_size)
      2'b00: begin
        new_entry.result  = {24'b0, in_result[7:0]};
        new_entry.byte_en = 4'b0001;
        nar_z             = (in_result[7:0] == 8'b0);
        nar_s             = in_result[7];
      end
      2'b01: begin
        new_entry.result  = {16'b0, in_result[15:0]};
        new_entry.byte_en = 4'b0011;
        nar_z             = (in_result[15:0] == 16'b0);
        nar_s             = in_result[15];
      end
      default: begin
        new_entry.result  = in_result;
        new_entry.byte_en = 4'b1111;
      end
    endcase
  end

  assign new_flags = {in_c, in_v, nar_s, nar_z};

  // A direct PSW load wins over any same-cycle commit from an accepted result.
  always_comb begin
    psw_next = psw_flags;
    if (psw_we)
      psw_next = psw_wdata;
    else if (accept)
      psw_next = (new_flags & in_flag_we) | (psw_flags & ~in_flag_we);
  end

  always_ff @(posedge clk) begin
    if (rst) psw_flags <= 4'b0000;
    else     psw_flags <= psw_next;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold   <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (drain) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        hold   <= mem[rd_ptr];
      end
      case ({accept, drain})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // An empty FIFO presents the last drained entry so the head outputs hold.
  assign head        = out_valid ? mem[rd_ptr] : hold;
  assign out_result  = head.result;
  assign out_byte_en = head.byte_en;
  assign out_dest    = head.dest;
  assign out_wb_en   = head.wb_en;

`ifdef V60_ALU_RESULT_FLAG_BYPASS_EN
  assign cond_flags = psw_next;
`else
  assign cond_flags = psw_flags;
`endif

  always_comb begin
    logic c, v, s, z;
    {c, v, s, z} = cond_flags;
    cond_true    = 1'b0;
    case (cond_code)
      4'd0:  cond_true = v;
      4'd1:  cond_true = !v;
      4'd2:  cond_true = c;
      4'd3:  cond_true = !c;
      4'd4:  cond_true = z;
      4'd5:  cond_true = !z;
      4'd6:  cond_true = c | z;
      4'd7:  cond_true = !(c | z);
      4'd8:  cond_true = s;
      4'd9:  cond_true = !s;
      4'd10: cond_true = 1'b1;
      4'd11: cond_true = 1'b0;
      4'd12: cond_true = s ^ v;
      4'd13: cond_true = !(s ^ v);
      4'd14: cond_true = (s ^ v) | z;
      default: cond_true = !((s ^ v) | z);
    endcase
  end

endmodule

// File: tb/tb_v60_alu_result_stage.sv
// Self-checking bench for v60_alu_result_stage: directed scenarios then randomized traffic against a queue model.
module tb_v60_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_c, in_v, in_z, in_s;
  logic [1:0]  in_size;
  logic [3:0]  in_flag_we;
  logic [4:0]  in_dest;
  logic        in_wb_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_byte_en;
  logic [4:0]  out_dest;
  logic        out_wb_en;
  logic        psw_we;
  logic [3:0]  psw_wdata;
  logic [3:0]  psw_flags;
  logic [3:0]  cond_code;
  logic        cond_true;

  always #5 clk = ~clk;

  v60_alu_result_stage #(.DEPTH(2), .DEST_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_c(in_c), .in_v(in_v), .in_z(in_z), .in_s(in_s),
    .in_size(in_size), .in_flag_we(in_flag_we), .in_dest(in_dest), .in_wb_en(in_wb_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_byte_en(out_byte_en), .out_dest(out_dest), .out_wb_en(out_wb_en),
    .psw_we(psw_we), .psw_wdata(psw_wdata), .psw_flags(psw_flags),
    .cond_code(cond_code), .cond_true(cond_true)
  );

  typedef struct {
    logic [31:0] r;
    logic [3:0]  be;
    logic [4:0]  d;
    logic        wb;
  } ent_t;

  ent_t       q[$];
  ent_t       hold;
  logic [3:0] mpsw;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Branch condition table, flags ordered {C,V,S,Z}.
  function automatic logic mcond(input logic [3:0] f, input logic [3:0] cc);
    logic c, v, s, z;
    c = f[3]; v = f[2]; s = f[1]; z = f[0];
    case (cc)
      0: return v;              1: return !v;
      2: return c;              3: return !c;
      4: return z;              5: return !z;
      6: return c || z;         7: return !(c || z);
      8: return s;              9: return !s;
      10: return 1'b1;          11: return 1'b0;
      12: return s != v;        13: return s == v;
      14: return (s != v) || z;
      default: return !((s != v) || z);
    endcase
  endfunction

  function automatic void mnarrow(input logic [31:0] r, input logic [1:0] sz, input logic z, input logic s,
                                  output logic [31:0] res, output logic [3:0] be, output logic nz, output logic ns);
    if (sz == 2'd0) begin
      res = r % 256; be = 4'b0001; nz = (res == 0); ns = (res >= 128);
    end else if (sz == 2'd1) begin
      res = r % 65536; be = 4'b0011; nz = (res == 0); ns = (res >= 32768);
    end else begin
      res = r; be = 4'b1111; nz = z; ns = s;
    end
  endfunction

  // Check all outputs against the model, then advance DUT and model through one clock edge.
  task automatic tick();
    ent_t        h, e;
    logic        acc, drn, nz, ns;
    logic [3:0]  nxt, nf;
    #1;
    h = (q.size() != 0) ? q[0] : hold;
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() != 0);
    chk("out_result", out_result, h.r);
    chk("out_byte_en", out_byte_en, h.be);
    chk("out_dest", out_dest, h.d);
    chk("out_wb_en", out_wb_en, h.wb);
    chk("psw_flags", psw_flags, mpsw);
    acc = in_valid && (q.size() < 2);
    drn = (q.size() != 0) && out_ready;
    mnarrow(in_result, in_size, in_z, in_s, e.r, e.be, nz, ns);
    e.d = in_dest; e.wb = in_wb_en;
    nf  = {in_c, in_v, ns, nz};
    nxt = mpsw;
    if (psw_we) nxt = psw_wdata;
    else if (acc) for (int i = 0; i < 4; i++) if (in_flag_we[i]) nxt[i] = nf[i];
`ifdef V60_ALU_RESULT_FLAG_BYPASS_EN
    if (!rst) chk("cond_true", cond_true, mcond(nxt, cond_code));
`else
    chk("cond_true", cond_true, mcond(mpsw, cond_code));
`endif
    @(posedge clk);
    if (rst) begin
      q.delete();
      hold = '{default: '0};
      mpsw = 4'b0000;
    end else begin
      if (drn) hold = q.pop_front();
      if (acc) q.push_back(e);
      mpsw = nxt;
    end
    #1;
  endtask

  task automatic set_in(input logic [31:0] r, input logic [1:0] sz, input logic [3:0] cvsz,
                        input logic [3:0] we, input logic [4:0] d);
    in_valid = 1'b1; in_result = r; in_size = sz;
    {in_c, in_v, in_s, in_z} = cvsz;
    in_flag_we = we; in_dest = d; in_wb_en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_result = '0; {in_c, in_v, in_z, in_s} = '0;
    in_size = '0; in_flag_we = '0; in_dest = '0; in_wb_en = 1'b0; out_ready = 1'b1;
    psw_we = 1'b0; psw_wdata = '0; cond_code = '0;
    hold = '{default: '0}; mpsw = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state across every condition code.
    for (int cc = 0; cc < 16; cc++) begin
      cond_code = 4'(cc);
      tick();
    end

    // Byte accept zeroes result and sets Z.
    set_in(32'h0000_1200, 2'b00, 4'b0000, 4'b1111, 5'd3);
    tick();
    in_valid = 1'b0; cond_code = 4'd4;
    #1;
    chk("byte_result", out_result, 32'h0);
    chk("byte_be", out_byte_en, 4'b0001);
    chk("byte_psw_z", psw_flags[0], 1'b1);
    chk("byte_cond_e", cond_true, 1'b1);
    tick();

    // Halfword sign.
    set_in(32'h0000_8001, 2'b01, 4'b0000, 4'b1111, 5'd7);
    tick();
    in_valid = 1'b0; cond_code = 4'd8;
    #1;
    chk("half_result", out_result, 32'h0000_8001);
    chk("half_cond_n", cond_true, 1'b1);
    tick();
    cond_code = 4'd9;
    tick();

    // Backpressure: two accepts fill, third stalls, then in-order drain.
    out_ready = 1'b0;
    set_in(32'hAAAA_0001, 2'b10, 4'b0000, 4'b0000, 5'd1); tick();
    set_in(32'hBBBB_0002, 2'b10, 4'b0000, 4'b0000, 5'd2); tick();
    set_in(32'hCCCC_0003, 2'b10, 4'b0000, 4'b0000, 5'd3);
    #1;
    chk("full_in_ready", in_ready, 1'b0);
    tick(); tick();
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("drain_a", out_result, 32'hAAAA_0001);
    tick();
    chk("drain_b", out_result, 32'hBBBB_0002);
    chk("ready_after_drain", in_ready, 1'b1);
    tick(); tick();

    // Masked commit, then PSW load overriding a same-cycle commit.
    psw_we = 1'b1; psw_wdata = 4'b1111; tick();
    psw_we = 1'b0;
    set_in(32'h1, 2'b10, 4'b0000, 4'b0101, 5'd4); tick();
    in_valid = 1'b0;
    #1;
    chk("masked_psw", psw_flags, 4'b1010);
    set_in(32'h0, 2'b10, 4'b1111, 4'b1111, 5'd5);
    psw_we = 1'b1; psw_wdata = 4'b0011; tick();
    psw_we = 1'b0; in_valid = 1'b0;
    #1;
    chk("psw_override", psw_flags, 4'b0011);
    tick(); tick();

    // Signed conditions.
    psw_we = 1'b1; psw_wdata = 4'b0010; tick();
    psw_we = 1'b0;
    for (int cc = 12; cc < 16; cc++) begin cond_code = 4'(cc); tick(); end
    psw_we = 1'b1; psw_wdata = 4'b0110; tick();
    psw_we = 1'b0;
    for (int cc = 12; cc < 16; cc++) begin cond_code = 4'(cc); tick(); end

    // Reset mid-stream with a full FIFO.
    out_ready = 1'b0;
    set_in(32'h1111_1111, 2'b10, 4'b1111, 4'b1111, 5'd8); tick();
    set_in(32'h2222_2222, 2'b10, 4'b1111, 4'b1111, 5'd9); tick();
    in_valid = 1'b0; rst = 1'b1; tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_psw", psw_flags, 4'b0000);
    chk("rst_in_ready", in_ready, 1'b1);
    set_in(32'h0, 2'b10, 4'b0001, 4'b0001, 5'd1); cond_code = 4'd4;
    tick();
    in_valid = 1'b0;
    tick();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(0, 59) == 0);
      in_valid   = $urandom_range(0, 1);
      in_result  = $urandom();
      if ($urandom_range(0, 3) == 0) in_result = in_result & 32'hFFFF_0000;
      {in_c, in_v, in_z, in_s} = 4'($urandom());
      in_size    = 2'($urandom());
      in_flag_we = 4'($urandom());
      in_dest    = 5'($urandom());
      in_wb_en   = $urandom_range(0, 1);
      out_ready  = ($urandom_range(0, 2) != 0);
      psw_we     = ($urandom_range(0, 7) == 0);
      psw_wdata  = 4'($urandom());
      cond_code  = 4'($urandom());
      tick();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
